// File: rtl/ah_pl2ddr_pkg.sv
// Shared types and constants for the PL2DDR burst scheduler.
// Pure declarations: no latency, no flow control.
package ah_pl2ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned WORD_SHIFT = 2;

  typedef struct packed {
    logic [31:0] addr_low;
    logic [31:0] addr_high;
    logic        wrap;
    logic [31:0] total_words;
  } cfg_t;

endpackage

// File: rtl/ah_pl2ddr_burst_scheduler_if.sv
// Burst command channel between the scheduler (master) and the AXI write engine (slave).
// One burst outstanding: tx_init starts it, tx_done or axi_error ends it.
interface ah_pl2ddr_burst_scheduler_if;
  logic        tx_init;
  logic [31:0] tx_addr;
  logic [8:0]  tx_burst_len;
  logic        tx_done;
  logic        axi_error;

  modport master (output tx_init, tx_addr, tx_burst_len, input tx_done, axi_error);
  modport slave  (input tx_init, tx_addr, tx_burst_len, output tx_done, axi_error);
endinterface

// File: rtl/ah_pl2ddr_burst_sizer.sv
// Next burst size: min of nominal length, words left, words to window end and words to 4 KB page end.
// Purely combinational, no backpressure.
module ah_pl2ddr_burst_sizer
  import ah_pl2ddr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic [31:0] cur_addr,
  input  logic [31:0] addr_high,
  input  logic [31:0] total_words,
  input  logic [31:0] words_sent,
  output logic [8:0]  need
);
  logic [32:0] region_bytes;
  logic [31:0] region_words;
  logic [31:0] page_words;
  logic [31:0] remaining;
  logic [31:0] need_w;
  logic        unused_bits;

  always_comb begin
    // 33 bits so a window ending at 0xFFFFFFFF does not overflow
    region_bytes = {1'b0, addr_high} - {1'b0, cur_addr} + 33'd1;
    region_words = {1'b0, region_bytes[32:2]};
    page_words   = (32'(PAGE_BYTES) - {20'd0, cur_addr[11:0]}) >> WORD_SHIFT;
    remaining    = (total_words == '0) ? '1 : total_words - words_sent;
    need_w = 32'(BURST_LEN);
    if (remaining < need_w)    need_w = remaining;
    if (region_words < need_w) need_w = region_words;
    if (page_words < need_w)   need_w = page_words;
    need = need_w[8:0];
  end

  assign unused_bits = ^{region_bytes[1:0], need_w[31:9]};

endmodule

// File: rtl/ah_pl2ddr_burst_scheduler.sv
// Paces AXI write bursts from the staging fill level and walks the DDR window, with optional ring wrap.
// tx_init one cycle after data qualifies; next burst two cycles after tx_done; transfer_en holds off new bursts.
module ah_pl2ddr_burst_scheduler
  import ah_pl2ddr_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned AVAIL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            cfg_addr_low,
  input  logic [31:0]            cfg_addr_high,
  input  logic                   cfg_wrap,
  input  logic [31:0]            cfg_total_words,
  input  logic                   transfer_en,
  input  logic [AVAIL_WIDTH-1:0] data_available,
  ah_pl2ddr_burst_scheduler_if.master tx,
  output logic                   busy,
  output logic                   done,
  output logic                   full,
  output logic                   error,
  output logic [31:0]            words_sent,
  output logic [31:0]            cur_addr,
  output logic [15:0]            wrap_count,
  output logic [2:0]             state
);
  localparam logic [31:0] ALIGN_MASK = 32'(BURST_LEN * 4) - 32'd1;

  state_t      st;
  cfg_t        cfg_q;
  logic        stop_pending;
  logic [31:0] addr_q;
  logic [8:0]  len_q;
  logic [8:0]  need;
  logic [31:0] avail_w;
  logic [32:0] next_addr;
  logic        run_complete;
  logic        cfg_bad;

  ah_pl2ddr_burst_sizer #(.BURST_LEN(BURST_LEN)) u_sizer (
    .cur_addr    (cur_addr),
    .addr_high   (cfg_q.addr_high),
    .total_words (cfg_q.total_words),
    .words_sent  (words_sent),
    .need        (need)
  );

  assign avail_w      = 32'(data_available);
  assign next_addr    = {1'b0, cur_addr} + {22'd0, len_q, 2'b00};
  assign run_complete = (cfg_q.total_words != '0) && (words_sent == cfg_q.total_words);
  assign cfg_bad      = ((cfg_addr_low & ALIGN_MASK) != '0) ||
                        ({1'b0, cfg_addr_high} < ({1'b0, cfg_addr_low} + 33'd3));

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      cfg_q        <= '0;
      stop_pending <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      words_sent   <= '0;
      cur_addr     <= '0;
      wrap_count   <= '0;
      full         <= 1'b0;
    end else begin
      // stop is a request to drain; it stays latched until the run ends
      if (stop && (st inside {ST_WAIT_DATA, ST_ISSUE, ST_WAIT_DONE})) stop_pending <= 1'b1;
      case (st)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            if (cfg_bad) begin
              st <= ST_ERROR;
            end else begin
              cfg_q        <= '{addr_low: cfg_addr_low, addr_high: cfg_addr_high,
                                wrap: cfg_wrap, total_words: cfg_total_words};
              cur_addr     <= cfg_addr_low;
              words_sent   <= '0;
              wrap_count   <= '0;
              full         <= 1'b0;
              stop_pending <= 1'b0;
              st           <= ST_WAIT_DATA;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (tx.axi_error) begin
            st <= ST_ERROR;
          end else if (run_complete) begin
            st <= ST_DONE;
          end else if (stop_pending && avail_w == '0) begin
            st <= ST_DONE;
          end else if (transfer_en && avail_w >= 32'(need)) begin
            addr_q <= cur_addr;
            len_q  <= need;
            st     <= ST_ISSUE;
          end else if (transfer_en && stop_pending) begin
            // avail < need <= 256 here, so the low bits hold the whole value
            addr_q <= cur_addr;
            len_q  <= avail_w[8:0];
            st     <= ST_ISSUE;
          end
        end
        ST_ISSUE: st <= tx.axi_error ? ST_ERROR : ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (tx.axi_error) begin
            st <= ST_ERROR;
          end else if (tx.tx_done) begin
            words_sent <= words_sent + 32'(len_q);
            if (next_addr > {1'b0, cfg_q.addr_high}) begin
              if (cfg_q.wrap) begin
                cur_addr <= cfg_q.addr_low;
                if (wrap_count != 16'hFFFF) wrap_count <= wrap_count + 16'd1;
                st <= ST_WAIT_DATA;
              end else begin
                full <= 1'b1;
                st   <= ST_DONE;
              end
            end else begin
              cur_addr <= next_addr[31:0];
              st       <= ST_WAIT_DATA;
            end
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_init      = (st == ST_ISSUE);
  assign tx.tx_addr      = addr_q;
  assign tx.tx_burst_len = len_q;
  assign busy            = st inside {ST_WAIT_DATA, ST_ISSUE, ST_WAIT_DONE};
  assign done            = (st == ST_DONE);
  assign error           = (st == ST_ERROR);
  assign state           = st;

endmodule

// File: tb/tb_ah_pl2ddr_burst_scheduler.sv
// Randomised scoreboard bench for the PL2DDR burst scheduler plus direct checks of the sizer.
module tb_ah_pl2ddr_burst_scheduler;
  localparam int AW = 10;

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  len;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst, start, stop, cfg_wrap, transfer_en;
  logic [31:0]   cfg_addr_low, cfg_addr_high, cfg_total_words;
  logic [AW-1:0] data_available;
  logic          busy, done, full, error;
  logic [31:0]   words_sent, cur_addr;
  logic [15:0]   wrap_count;
  logic [2:0]    state;

  logic [31:0]   sz_cur, sz_high, sz_total, sz_sent;
  logic [8:0]    sz_need;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  burst_t exp_q[$];

  ah_pl2ddr_burst_scheduler_if tx_if ();

  ah_pl2ddr_burst_scheduler #(.BURST_LEN(16), .AVAIL_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_addr_low(cfg_addr_low), .cfg_addr_high(cfg_addr_high), .cfg_wrap(cfg_wrap),
    .cfg_total_words(cfg_total_words), .transfer_en(transfer_en), .data_available(data_available),
    .tx(tx_if), .busy(busy), .done(done), .full(full), .error(error),
    .words_sent(words_sent), .cur_addr(cur_addr), .wrap_count(wrap_count), .state(state)
  );

  ah_pl2ddr_burst_sizer #(.BURST_LEN(32)) u_sizer32 (
    .cur_addr(sz_cur), .addr_high(sz_high), .total_words(sz_total),
    .words_sent(sz_sent), .need(sz_need)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_init must match the head of the expected burst queue.
  initial begin
    burst_t b;
    forever begin
      @(negedge clk);
      if (tx_if.tx_init) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_burst: addr 0x%0h len %0d, none expected",
                   tx_if.tx_addr, tx_if.tx_burst_len);
        end else begin
          b = exp_q.pop_front();
          check("burst_addr", 64'(tx_if.tx_addr), 64'(b.addr));
          check("burst_len", 64'(tx_if.tx_burst_len), 64'(b.len));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Reference: the staging level is a finite pool consumed by each completed burst,
  // and a stop always arrives eventually, so the burst list depends only on the config.
  task automatic do_run(input string tag, input logic [31:0] low, input logic [31:0] high,
                        input bit wrap, input logic [31:0] total, input int level,
                        input int err_burst, input bit early_stop, input bit gate_en);
    burst_t b;
    longint cur, sent, rem, need, len, lv, region, page;
    int wraps, n, resp_wait, nburst, idle, d0;
    bit fl, errd, fin, stop_sent;
    logic [8:0] pend_len;

    cur = longint'(low); sent = 0; wraps = 0; fl = 0; errd = 0; n = 0; lv = level;
    forever begin
      if (total != 0 && sent == longint'(total)) break;
      rem    = (total == 0) ? (longint'(1) << 40) : longint'(total) - sent;
      region = (longint'(high) - cur + 1) / 4;
      page   = (4096 - (cur % 4096)) / 4;
      need = 16;
      if (rem < need)    need = rem;
      if (region < need) need = region;
      if (page < need)   need = page;
      if (lv >= need) len = need;
      else if (lv == 0) break;
      else len = lv;
      b.addr = cur[31:0];
      b.len  = len[8:0];
      exp_q.push_back(b);
      n++;
      if (n == err_burst) begin errd = 1; break; end
      sent += len;
      lv   -= len;
      if (cur + 4 * len > longint'(high)) begin
        if (wrap) begin cur = longint'(low); wraps++; end
        else begin fl = 1; break; end
      end else begin
        cur += 4 * len;
      end
    end

    d0 = done_cnt;
    cfg_addr_low = low; cfg_addr_high = high; cfg_wrap = wrap; cfg_total_words = total;
    data_available = AW'(level);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = early_stop;
    resp_wait = 0; nburst = 0; idle = 0; stop_sent = early_stop; fin = 0; pend_len = '0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(posedge clk); #1;
      stop = 1'b0;
      tx_if.tx_done = 1'b0;
      tx_if.axi_error = 1'b0;
      if (gate_en) transfer_en = ($urandom_range(0, 3) != 0);
      if (done || error) begin
        fin = 1;
      end else if (resp_wait > 0) begin
        resp_wait--;
        idle = 0;
        if (resp_wait == 0) begin
          tx_if.tx_done = 1'b1;
          tx_if.axi_error = (nburst == err_burst);
          if (nburst != err_burst) data_available = data_available - AW'(pend_len);
        end
      end else if (tx_if.tx_init) begin
        nburst++;
        pend_len = tx_if.tx_burst_len;
        resp_wait = $urandom_range(1, 4);
        idle = 0;
      end else begin
        idle++;
        if (idle >= 30 && !stop_sent) begin
          stop = 1'b1;
          stop_sent = 1;
        end
      end
    end
    transfer_en = 1'b1; stop = 1'b0; tx_if.tx_done = 1'b0; tx_if.axi_error = 1'b0;

    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: run still busy, state %0d, expected done or error", tag, state);
    end
    check({tag, "_words_sent"}, 64'(words_sent), 64'(sent));
    check({tag, "_wrap_count"}, 64'(wrap_count), 64'(wraps));
    check({tag, "_full"}, 64'(full), 64'(fl));
    check({tag, "_error"}, 64'(error), 64'(errd));
    if (!fl) check({tag, "_cur_addr"}, 64'(cur_addr), 64'(cur));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_state_after"}, 64'(state), errd ? 64'd5 : 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), errd ? 64'd0 : 64'd1);
    check({tag, "_bursts_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    burst_t b;
    bit seen;
    logic [31:0] lo;
    int w;

    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_wrap = 1'b0; transfer_en = 1'b1;
    cfg_addr_low = '0; cfg_addr_high = '0; cfg_total_words = '0; data_available = '0;
    tx_if.tx_done = 1'b0; tx_if.axi_error = 1'b0;
    sz_cur = '0; sz_high = '0; sz_total = '0; sz_sent = '0;
    repeat (3) @(posedge clk); #1;

    check("rst_tx_init", 64'(tx_if.tx_init), 64'd0);
    check("rst_tx_addr", 64'(tx_if.tx_addr), 64'd0);
    check("rst_tx_len", 64'(tx_if.tx_burst_len), 64'd0);
    check("rst_flags", 64'({busy, done, full, error}), 64'd0);
    check("rst_counters", 64'(words_sent) | 64'(cur_addr) | 64'(wrap_count), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    rst = 1'b0;

    // Sizer alone with 32-word bursts: the 4 KB page clamp
    sz_cur = 32'h0010_0FC0; sz_high = 32'h001F_FFFF; #1;
    check("sizer_page_split", 64'(sz_need), 64'd16);
    sz_cur = 32'h0010_1000; #1;
    check("sizer_after_page", 64'(sz_need), 64'd32);
    sz_total = 32'd100; sz_sent = 32'd90; #1;
    check("sizer_remaining", 64'(sz_need), 64'd10);
    sz_high = 32'h0010_100B; #1;
    check("sizer_region", 64'(sz_need), 64'd3);

    // Bad configurations go straight to ERROR
    @(posedge clk); #1;
    cfg_addr_low = 32'h0010_0020; cfg_addr_high = 32'h0010_03FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_misaligned_error", 64'({error, busy, state}), 64'({1'b1, 1'b0, 3'd5}));
    cfg_addr_low = 32'h0010_0000; cfg_addr_high = 32'h0010_0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_small_window_error", 64'({error, state}), 64'({1'b1, 3'd5}));

    do_run("basic", 32'h0010_0000, 32'h0010_03FF, 1'b0, 32'd64, 64, 0, 1'b0, 1'b0);
    do_run("wrap", 32'h0010_0000, 32'h0010_00FF, 1'b1, 32'd0, 320, 0, 1'b0, 1'b0);
    do_run("nowrap_full", 32'h0010_0000, 32'h0010_00FF, 1'b0, 32'd0, 320, 0, 1'b0, 1'b0);
    do_run("flush", 32'h0010_0000, 32'h0010_03FF, 1'b0, 32'd0, 5, 0, 1'b0, 1'b0);
    do_run("axi_err", 32'h0010_0000, 32'h0010_03FF, 1'b0, 32'd64, 64, 2, 1'b0, 1'b0);
    do_run("after_err", 32'h0010_0000, 32'h0010_03FF, 1'b0, 32'd48, 100, 0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      lo = 32'h0010_0000 + 32'(64 * $urandom_range(0, 127));
      w  = $urandom_range(1, 80);
      do_run("rand", lo, lo + 32'(4 * w) - 32'd1, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 200)),
             $urandom_range(0, 200),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
             1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset while a burst is in flight
    b.addr = 32'h0010_0000; b.len = 9'd16;
    exp_q.push_back(b);
    cfg_addr_low = 32'h0010_0000; cfg_addr_high = 32'h0010_03FF; cfg_wrap = 1'b0;
    cfg_total_words = 32'd0; data_available = AW'(64); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (tx_if.tx_init) seen = 1;
    end
    check("rst_mid_tx_init_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_state", 64'(state), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_tx_addr", 64'(tx_if.tx_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ah_pl2ddr_burst_scheduler.md
# ah_pl2ddr_burst_scheduler

Single-clock burst scheduler for the PL2DDR capture path. Watches the BRAM staging fill level, decides when and how large each AXI write burst is, and steps the DDR write address through a configured window with optional ring-buffer wrap. Drives the init/done handshake of the AXI master and reports progress, completion and errors to the command FSM.

## Interface
- `BURST_LEN`, 16: nominal burst length in 32-bit words; power of two, 1..256.
- `AVAIL_WIDTH`, 10: width of the fill-level input.
- `clk` in 1: system/AXI clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; latches cfg_* and begins a run. Ignored while busy.
- `stop` in 1: pulse; flushes remaining data, then finishes. Ignored when idle.
- `cfg_addr_low` in 32: first byte address of the window.
- `cfg_addr_high` in 32: last byte address of the window, inclusive.
- `cfg_wrap` in 1: 1 = ring buffer, 0 = stop when full.
- `cfg_total_words` in 32: words to transfer; 0 = unlimited.
- `transfer_en` in 1: 0 holds off new bursts; an issued burst always completes.
- `data_available` in AVAIL_WIDTH: words readable from staging BRAM.
- `tx_init` out 1: one-cycle burst start pulse to the AXI master.
- `tx_addr` out 32: burst start address.
- `tx_burst_len` out 9: burst length in words.
- `tx_done` in 1: burst complete pulse.
- `axi_error` in 1: AXI response error.
- `busy` out 1, `done` out 1 (pulse), `full` out 1, `error` out 1.
- `words_sent` out 32, `cur_addr` out 32, `wrap_count` out 16.
- `state` out 3: FSM state encoding, for debug.

## Operation
- States: IDLE(0), WAIT_DATA(1), ISSUE(2), WAIT_DONE(3), DONE(4), ERROR(5).
- IDLE + start:
  - cfg_addr_low not aligned to BURST_LEN*4, or cfg_addr_high < cfg_addr_low+3 → ERROR.
  - Otherwise latch config, set cur_addr=low, clear words_sent, wrap_count, full, error, stop_pending → WAIT_DATA.
- stop while busy sets stop_pending, which is sticky for the rest of the run.
- Burst size `need = min(BURST_LEN, remaining, region_words, page_words)`:
  - `remaining = total - words_sent`; unlimited when total = 0.
  - `region_words = (high - cur_addr + 1) >> 2`.
  - `page_words = (4096 - cur_addr[11:0]) >> 2`, so no burst crosses a 4 KB boundary.
- WAIT_DATA, first matching rule wins:
  1. total ≠ 0 and remaining = 0 → DONE.
  2. stop_pending and data_available = 0 → DONE.
  3. transfer_en and data_available ≥ need → ISSUE with len = need.
  4. transfer_en and stop_pending → ISSUE with len = min(need, data_available).
- ISSUE: tx_init=1 for one cycle; tx_addr = cur_addr; tx_burst_len = len → WAIT_DONE.
- WAIT_DONE + tx_done:
  - words_sent += len.
  - Next address `cur_addr + 4*len`. If it exceeds high: with cfg_wrap, cur_addr = low and wrap_count++ (saturating); without wrap, full = 1 → DONE.
  - Otherwise → WAIT_DATA.
- axi_error in any busy state → ERROR. Error wins over a simultaneous tx_done, and that burst is not counted.
- ERROR: error = 1, busy = 0. Leaves only on start (re-validates config) or rst.
- DONE: done = 1 for one cycle → IDLE. words_sent, cur_addr and full hold until the next start.

## Timing
- Reset values: all outputs 0, state IDLE, tx_addr 0, tx_burst_len 0.
- busy = 1 in states 1–3.
- data_available sampled at edge N and satisfying the issue rule → tx_init high during cycle N+1.
- tx_addr and tx_burst_len are registered; stable from the tx_init cycle until the cycle after tx_done.
- tx_done at edge M → counters updated at M+1. The next tx_init is earliest at M+2.
- Only one burst is outstanding at a time. A tx_done outside WAIT_DONE is ignored.
- rst mid-burst → IDLE next edge. The AXI master shares rst; no drain is performed.
- start and stop in the same cycle while IDLE: start taken, stop ignored.

## Structure
- Package `ah_pl2ddr_pkg`: state enum, 4 KB page constant, word-size shift (2).
- Sub-module `ah_pl2ddr_burst_sizer`: combinational min-of-four producing `need`, so it can be unit-tested alone.
- Top module holds the FSM and counters; instantiated beside `ah_pl2ddr_cmd_fsm` in the PL2DDR top.

## Test plan
- Basic run, BURST_LEN=16, low=0x00100000, high=0x001003FF, total=64, avail held at 16 → 4 bursts at 0x100000, 0x100040, 0x100080, 0x1000C0; done pulse; words_sent=64.
- Wrap: 256-byte window, total=0, cfg_wrap=1, 20 bursts → tx_addr returns to low after every 4 bursts; wrap_count=5.
- No-wrap full: same window, cfg_wrap=0 → DONE after 4 bursts; full=1; no 5th tx_init.
- Flush: avail=5, stop pulse → single burst len=5, then done; words_sent=5.
- Page boundary: low=0x00100FC0 with BURST_LEN=32 → first burst len=16 to 0x100FC0, then len=32 from 0x101000.
- Error: axi_error in the same cycle as tx_done → ERROR; words_sent unchanged; error=1. A following start clears it and a new run begins.
